// File: rtl/key_debounce_pkg.sv
// Shared types and default parameters for the key_debounce block.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } kd_state_t;

  localparam int unsigned DefStableCycles = 4;
  localparam int unsigned DefRepeatDelay  = 8;
  localparam int unsigned DefRepeatPeriod = 3;

endpackage

// File: rtl/key_debounce_if.sv
// Raw key input and conditioned outputs of key_debounce, bundled as one interface.
interface key_debounce_if;
  logic key;
  logic key_level;
  logic key_press;
  logic key_release;

  modport master (output key, input key_level, input key_press, input key_release);
  modport slave  (input key, output key_level, output key_press, output key_release);
endinterface

// File: rtl/key_debounce_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; synchronous active-high reset.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic q_q, q_d;

  always_comb begin
    s1_d = d;
    q_d  = s1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      q_q  <= 1'b0;
    end else begin
      s1_q <= s1_d;
      q_q  <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer producing a level and registered press/release strobes.
// Define KEY_DEBOUNCE_REPEAT_EN to add auto-repeat press strobes while the key is held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DefStableCycles
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
`endif
) (
  input  logic           clock,
  input  logic           reset,
  key_debounce_if.slave  kif
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  kd_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            key_s;
  logic            rep_fire;

  sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (kif.key),
    .q     (key_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (key_s) begin
          state_d = PRESS_CHECK;
          cnt_d   = CntW'(1);
        end
      end
      PRESS_CHECK: begin
        if (!key_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_CHECK;
          cnt_d   = CntW'(1);
        end
      end
      RELEASE_CHECK: begin
        if (key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepFirst = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepNext  = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_q, rep_d;
  logic            rep_phase_q, rep_phase_d;

  // Counts only while settled in PRESSED; frozen across RELEASE_CHECK bounces.
  always_comb begin
    rep_d       = rep_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    if (state_q == PRESSED && key_s) begin
      if (rep_q == (rep_phase_q ? RepNext : RepFirst)) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end else if (state_q != PRESSED && state_q != RELEASE_CHECK) begin
      rep_d       = '0;
      rep_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d | rep_fire;
      release_q <= release_d;
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;

endmodule

// File: doc/key_debounce.md
# key_debounce

Conditions a raw, asynchronous push-button input into clean single-cycle strobes. It sits directly upstream of the `dffe` storage stages and drives their `enable` inputs. One registered press strobe is produced per physical press, so a `dffe` captures `D` exactly once per key press. A debounced level output and a release strobe are also provided for downstream logic.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive synchronized samples required to accept a level change; must be ≥ 2.
- `REPEAT_DELAY`, default 8: cycles held in PRESSED before the first auto-repeat strobe. Used only with the macro defined.
- `REPEAT_PERIOD`, default 3: cycles between subsequent auto-repeat strobes; must be ≥ 1. Used only with the macro defined.
- `clock`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `key`  input  1  raw asynchronous button level; active high.
- `key_level`  output  1  debounced key level.
- `key_press`  output  1  one-cycle strobe on an accepted press (and on auto-repeat, if enabled); feeds `dffe.enable`.
- `key_release`  output  1  one-cycle strobe on an accepted release.

## Operation
- **Synchronizer.** Two flops, `key` → `s1` → `key_s`, both reset to 0. The FSM sees only `key_s`, never `key`.
- **Stability counter.** Width `$clog2(STABLE_CYCLES)`; cleared on every transition into RELEASED or PRESSED.
- **FSM states:** RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK. Reset state is RELEASED.
  - RELEASED: `key_s`=1 → PRESS_CHECK with cnt=1; otherwise stay.
  - PRESS_CHECK: `key_s`=0 → RELEASED, no strobe (bounce rejected). `key_s`=1 and cnt=STABLE_CYCLES−1 → PRESSED. Otherwise cnt++.
  - PRESSED: `key_s`=0 → RELEASE_CHECK with cnt=1; otherwise stay.
  - RELEASE_CHECK: `key_s`=1 → PRESSED, no strobe. `key_s`=0 and cnt=STABLE_CYCLES−1 → RELEASED. Otherwise cnt++.
- **Outputs.** All outputs are registered.
  - `key_level`=1 in PRESSED and RELEASE_CHECK, and 0 otherwise.
  - `key_press`=1 for exactly the first cycle after the PRESS_CHECK→PRESSED transition.
  - `key_release`=1 for exactly the first cycle after the RELEASE_CHECK→RELEASED transition.
  - PRESSED↔RELEASE_CHECK bounces never strobe.
- **Reset.** All outputs reset to 0; FSM goes to RELEASED; sync flops go to 0.
- **Reset mid-operation** (any state, including mid-check or mid-repeat): an in-flight strobe is dropped and no release strobe is generated. If `key` is still high after reset deasserts, the press is re-qualified from scratch.
- **Mutual exclusion.** `key_press` and `key_release` are never high in the same cycle.

## Timing
- Edge 1 is the first rising edge sampling `key`=1 with `key` held high thereafter.
- `key_level` and `key_press` go high after edge 2+STABLE_CYCLES (edge 6 with defaults). `key_press` falls after the next edge.
- Release latency is symmetric: `key_release` goes high 2+STABLE_CYCLES edges after `key` is first sampled 0.
- Any glitch shorter than STABLE_CYCLES synchronized samples has no effect on any output.
- Throughput: at most one press strobe per 2·STABLE_CYCLES cycles without repeat.

## Configuration
- Macro: `KEY_DEBOUNCE_REPEAT_EN`.
- **Defined:** while in PRESSED, a repeat counter counts cycles.
  - An extra `key_press` strobe is issued REPEAT_DELAY cycles after the initial strobe, then every REPEAT_PERIOD cycles.
  - The counter is cleared on leaving PRESSED.
  - The counter pauses during RELEASE_CHECK and resumes if the FSM bounces back to PRESSED.
- **Undefined:** the repeat counter and the REPEAT_* parameters have no hardware; exactly one `key_press` per accepted press.

## Structure
- **Package `key_debounce_pkg`:** state enum typedef `kd_state_t` (RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK) and the default parameter constants.
- **Sub-module `sync2`:** 2-flop synchronizer with ports `clock`, `reset`, `d`, `q`. It is reused by other blocks taking asynchronous inputs.
- The FSM, counters and output registers live in `key_debounce`.

## Test plan
All scenarios use STABLE_CYCLES=4.
- **Reset:** `reset` high for 3 cycles with `key`=1 → all outputs 0 throughout. After release, `key_press` is high for one cycle after edge 6 post-reset.
- **Clean press/release:** `key` high for 20 cycles, then low.
  - `key_level` rises after edge 6, with `key_press` high for exactly 1 cycle.
  - `key_release` is high for 1 cycle 6 edges after the fall; the press strobe count is 1.
- **Bounce:** `key` toggles 1,0,1,1,0,1 per cycle, then holds 1 → no strobes during toggling. A single `key_press` occurs 6 edges after the final rise.
- **Release glitch:** while PRESSED, `key` low for 2 cycles → `key_level` stays 1, no `key_release`, no second `key_press`.
- **Mid-check reset:** `reset` pulsed for 1 cycle on edge 4 of a press → no strobe before reset. The FSM is in RELEASED after the reset edge; the press is re-qualified after 6 further edges.
- **Auto-repeat** (macro defined, REPEAT_DELAY=8, REPEAT_PERIOD=3): hold `key` 30 cycles → strobes at t, t+8, t+11, t+14, … until release. No repeat strobe occurs after `key_release`.
